// File: rtl/data_mem_responder.sv
// Single-port data memory shared between a core port and a host port.
// A RUN/DRAIN/HOST arbiter hands ownership to the host after draining core reads.
module data_mem_responder #(
  parameter int reg_width = 12,
  parameter int addr_bits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [reg_width-1:0] core_addr,
  input  logic [reg_width-1:0] core_wdata,
  input  logic                 core_wr,
  input  logic                 core_rd,
  output logic [reg_width-1:0] core_rdata,
  output logic                 core_rvalid,
  output logic                 core_stall,
  input  logic                 host_hold,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [reg_width-1:0] host_addr,
  input  logic [reg_width-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [reg_width-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic [15:0]          wr_count
);

  localparam int DEPTH = 2 ** addr_bits;
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOST  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [reg_width-1:0] mem [DEPTH];
  logic [reg_width-1:0] core_rdata_q, host_rdata_q;
  logic                 core_rvalid_q, host_rvalid_q;
  logic [15:0]          wr_count_q;

  logic                 core_en, host_en;
  logic                 core_we, mem_we, core_re, host_re;
  logic [addr_bits-1:0] mem_addr;
  logic [reg_width-1:0] mem_wdata, rd_word;

  // Owners are mutually exclusive, so one shared address/data port suffices.
  always_comb begin
    core_en   = (state_q == RUN);
    host_en   = (state_q == HOST);
    core_we   = core_en & core_wr;
    core_re   = core_en & core_rd;
    host_re   = host_en & host_req & ~host_we;
    mem_we    = core_we | (host_en & host_req & host_we);
    mem_addr  = host_en ? host_addr[addr_bits-1:0] : core_addr[addr_bits-1:0];
    mem_wdata = host_en ? host_wdata : core_wdata;
    // Write-first: a same-cycle core write forwards straight to the read result.
    rd_word   = core_we ? core_wdata : mem[mem_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (host_hold) state_d = DRAIN;
      DRAIN:   state_d = HOST;
      HOST:    if (!host_hold) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      core_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      core_rvalid_q <= core_re;
      host_rvalid_q <= host_re;
      if (core_re) core_rdata_q <= rd_word;
      if (host_re) host_rdata_q <= rd_word;
      if (core_we && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  generate
    if (reg_width > addr_bits) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^{core_addr[reg_width-1:addr_bits],
                                host_addr[reg_width-1:addr_bits]};
    end
  endgenerate

  assign core_rdata  = core_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign wr_count    = wr_count_q;
  assign core_stall  = (state_q != RUN);
  assign host_gnt    = (state_q == HOST);

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: reg_width, 12, data and address word width.
REQ-002 Parameter: addr_bits, 8, implemented address bits; depth = 2**addr_bits words.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: core_addr  input  reg_width  core data-memory address.
REQ-006 Port: core_wdata  input  reg_width  core write data.
REQ-007 Port: core_wr  input  1  core write strobe, one word per cycle high.
REQ-008 Port: core_rd  input  1  core read strobe, one word per cycle high.
REQ-009 Port: core_rdata  output  reg_width  read data to core.
REQ-010 Port: core_rvalid  output  1  core_rdata valid this cycle.
REQ-011 Port: core_stall  output  1  core requests are not being accepted.
REQ-012 Port: host_hold  input  1  host request to take ownership of memory.
REQ-013 Port: host_req, host_we  input  1 each  host access strobe; write when host_we=1, else read.
REQ-014 Port: host_addr, host_wdata  input  reg_width each  host address and write data.
REQ-015 Port: host_gnt  output  1  host owns memory.
REQ-016 Port: host_rdata  output  reg_width; host_rvalid  output  1  host read return.
REQ-017 Port: wr_count  output  16  saturating count of accepted core writes.

Function
REQ-018 Storage SHALL be depth x reg_width words; only addr_bits LSBs of any address are used (upper bits ignored, addresses wrap).
REQ-019 FSM states SHALL be RUN, DRAIN, HOST; core_stall = (state != RUN); host_gnt = (state == HOST).
REQ-020 RUN: core_wr writes core_wdata at core_addr at that edge; core_rd returns data with core_rvalid high exactly one cycle later (latency 1).
REQ-021 RUN, core_wr and core_rd same cycle: write performed; read returns the newly written word (write-first).
REQ-022 Back-to-back core reads SHALL sustain one result per cycle, in issue order.
REQ-023 RUN and host_hold=1: core request in that cycle is still accepted; next state DRAIN.
REQ-024 DRAIN: core requests ignored; any pending core read completes (core_rvalid this cycle); next state HOST unconditionally.
REQ-025 HOST: core_wr/core_rd ignored, no memory or wr_count effect, core_rvalid 0.
REQ-026 HOST, host_req=1: host_we=1 writes host_wdata; host_we=0 returns word with host_rvalid one cycle later, same write-first rule versus no concurrent writer.
REQ-027 HOST and host_hold=0: next state RUN; a host read issued in the leaving cycle still returns host_rvalid next cycle.
REQ-028 host_req outside HOST SHALL be ignored (no write, no host_rvalid).
REQ-029 core_rvalid and host_rvalid SHALL be single-cycle pulses; core_rdata/host_rdata hold last returned value otherwise.
REQ-030 wr_count increments by 1 per accepted core write; saturates at 16'hFFFF with no wrap.

Reset
REQ-031 reset=0 SHALL asynchronously force: state RUN, core_rdata 0, core_rvalid 0, host_rdata 0, host_rvalid 0, wr_count 0; hence core_stall 0, host_gnt 0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset mid-operation SHALL discard any pending read; no rvalid pulse after reset release for a request issued before reset.
REQ-034 First access after reset release SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-035 RUN: write 12'h5A3 @ 12'h010, then read 12'h010 -> core_rvalid next cycle, core_rdata 12'h5A3, wr_count 1.
REQ-036 Write 12'h0AB @ 12'h105, read 12'h005 (addr_bits=8) -> core_rdata 12'h0AB (wrap); same-cycle write 12'h777 + read @ 12'h020 -> next cycle core_rdata 12'h777.
REQ-037 Core read issued with host_hold rising -> DRAIN cycle shows core_rvalid; next cycle host_gnt 1, core_stall 1; core_wr during HOST leaves memory and wr_count unchanged.
REQ-038 HOST: host write 12'hFFF @ 12'h0FF, host read 12'h0FF -> host_rvalid next cycle, 12'hFFF; drop host_hold -> RUN next cycle, core read 12'h0FF returns 12'hFFF.
REQ-039 Issue core read, assert reset=0 before next edge -> all outputs 0 immediately, no core_rvalid after release; memory data preserved.
REQ-040 Force 65537 core writes -> wr_count holds 16'hFFFF.
